// File: rtl/iotdf_pkg.sv
// Shared definitions for the iotdf_gen2 filter: function-select codes,
// width helpers and the configuration legality check.
package iotdf_pkg;

   typedef enum logic [2:0] {
      FN_NONE    = 3'd0,
      FN_MAX     = 3'd1,
      FN_MIN     = 3'd2,
      FN_AVG     = 3'd3,
      FN_INRANGE = 3'd4,
      FN_EXRANGE = 3'd5,
      FN_PEAKMAX = 3'd6,
      FN_PEAKMIN = 3'd7
   } fn_e;

   // beats per assembled sensor word
   function automatic int calc_beats(input int data_w, input int in_w);
      return data_w / in_w;
   endfunction

   function automatic int calc_grp_log2(input int group_n);
      return $clog2(group_n);
   endfunction

   function automatic bit cfg_ok(input int in_w, input int data_w, input int group_n);
      return (in_w > 0) && (data_w >= in_w) && ((data_w % in_w) == 0) &&
             (group_n >= 2) && ((group_n & (group_n - 1)) == 0);
   endfunction

endpackage

// File: rtl/iotdf_word_asm.sv
// Beat-to-word assembler: shifts accepted beats in MSB-first and pulses
// word_done the cycle after the last beat of a word lands.
module iotdf_word_asm
   import iotdf_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic [IN_W-1:0]   beat,
   output logic [DATA_W-1:0] cur,
   output logic              word_done
);

   localparam int BEATS = calc_beats(DATA_W, IN_W);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_base;

   // a beat accepted on the clearing edge counts as beat 0 of the new stream
   assign cnt_base = clear ? '0 : cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur       <= '0;
         cnt       <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (accept) begin
            cur <= DATA_W'({cur, beat});
            if (cnt_base == LAST_BEAT) begin
               cnt       <= '0;
               word_done <= 1'b1;
            end else begin
               cnt <= cnt_base + 1'b1;
            end
         end else if (clear) begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/iotdf_gen2.sv
// IoT data filter top: group max/min/avg, range extract/exclude, running peak.
// Build option IOTDF_AVG_ROUND_EN: group average rounds half-up instead of flooring.
module iotdf_gen2
   import iotdf_pkg::*;
#(
   parameter int IN_W    = 8,
   parameter int DATA_W  = 128,
   parameter int GROUP_N = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_en,
   input  logic [IN_W-1:0]   iot_in,
   input  logic [2:0]        fn_sel,
   input  logic [DATA_W-1:0] low,
   input  logic [DATA_W-1:0] high,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] iot_out
);

   localparam int GRP_LOG2 = calc_grp_log2(GROUP_N);
   localparam int ACC_W    = DATA_W + GRP_LOG2;
   localparam logic [GRP_LOG2-1:0] LAST_WORD = GRP_LOG2'(GROUP_N - 1);
`ifdef IOTDF_AVG_ROUND_EN
   localparam logic [ACC_W-1:0] AVG_BIAS = ACC_W'(GROUP_N / 2);
`else
   localparam logic [ACC_W-1:0] AVG_BIAS = '0;
`endif

   if (!cfg_ok(IN_W, DATA_W, GROUP_N)) begin : g_cfg_err
      $error("iotdf_gen2: DATA_W must be a multiple of IN_W and GROUP_N a power of two >= 2");
   end

   fn_e                 fn_cur;
   logic [2:0]          fn_q;
   logic                fn_chg;
   logic                accept;
   logic                word_done;
   logic [DATA_W-1:0]   cur;
   logic [ACC_W-1:0]    cur_ext;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    grp_val;
   logic [DATA_W-1:0]   grp_word;
   logic [DATA_W-1:0]   avg_word;
   logic [GRP_LOG2-1:0] word_cnt;
   logic                first_word;
   logic                last_word;
   logic [DATA_W-1:0]   peak;
   logic                peak_init;
   logic                peak_take;
   logic                in_range;
   logic                out_range;

   assign fn_cur = fn_e'(fn_sel);
   assign fn_chg = (fn_sel != fn_q);
   assign accept = in_en & ~busy;

   iotdf_word_asm #(
      .IN_W   (IN_W),
      .DATA_W (DATA_W)
   ) u_word_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (fn_chg),
      .accept    (accept),
      .beat      (iot_in),
      .cur       (cur),
      .word_done (word_done)
   );

   assign cur_ext    = {{GRP_LOG2{1'b0}}, cur};
   assign first_word = (word_cnt == '0);
   assign last_word  = (word_cnt == LAST_WORD);

   // running group value including the current word
   always_comb begin
      grp_val = cur_ext;
      if (!first_word) begin
         case (fn_cur)
            FN_MAX, FN_PEAKMAX: if (acc > cur_ext) grp_val = acc;
            FN_MIN, FN_PEAKMIN: if (acc < cur_ext) grp_val = acc;
            FN_AVG:             grp_val = acc + cur_ext;
            default:            grp_val = cur_ext;
         endcase
      end
   end

   assign grp_word = grp_val[DATA_W-1:0];
   assign avg_word = DATA_W'((grp_val + AVG_BIAS) >> GRP_LOG2);

   always_comb begin
      peak_take = 1'b0;
      if (!peak_init) begin
         peak_take = 1'b1;
      end else if (fn_cur == FN_PEAKMAX) begin
         peak_take = (grp_word > peak);
      end else if (fn_cur == FN_PEAKMIN) begin
         peak_take = (grp_word < peak);
      end
   end

   assign in_range  = (low < cur) && (cur < high);
   assign out_range = (cur < low) || (cur > high);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fn_q      <= 3'd0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         iot_out   <= '0;
         word_cnt  <= '0;
         acc       <= '0;
         peak      <= '0;
         peak_init <= 1'b0;
      end else begin
         fn_q  <= fn_sel;
         busy  <= 1'b0;
         valid <= 1'b0;
         if (fn_chg) begin
            word_cnt  <= '0;
            acc       <= '0;
            peak      <= '0;
            peak_init <= 1'b0;
         end else if (word_done) begin
            case (fn_cur)
               FN_MAX, FN_MIN, FN_AVG, FN_PEAKMAX, FN_PEAKMIN: begin
                  if (last_word) begin
                     word_cnt <= '0;
                     acc      <= '0;
                     busy     <= 1'b1;
                     case (fn_cur)
                        FN_AVG: begin
                           valid   <= 1'b1;
                           iot_out <= avg_word;
                        end
                        FN_PEAKMAX, FN_PEAKMIN: begin
                           if (peak_take) begin
                              peak      <= grp_word;
                              peak_init <= 1'b1;
                              valid     <= 1'b1;
                              iot_out   <= grp_word;
                           end
                        end
                        default: begin
                           valid   <= 1'b1;
                           iot_out <= grp_word;
                        end
                     endcase
                  end else begin
                     acc      <= grp_val;
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
               FN_INRANGE: begin
                  if (in_range) begin
                     valid   <= 1'b1;
                     iot_out <= cur;
                  end
               end
               FN_EXRANGE: begin
                  if (out_range) begin
                     valid   <= 1'b1;
                     iot_out <= cur;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iotdf_gen2.sv
// Bench for iotdf_gen2: default-parameter instance checked every cycle against
// a queue-based group model, plus a 16/64/4 instance for the async-reset case.
module tb_iotdf_gen2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_en, busy, valid;
   logic [7:0]   iot_in;
   logic [2:0]   fn_sel;
   logic [127:0] low, high, iot_out;

   logic         rst2, in_en2, busy2, valid2;
   logic [15:0]  iot_in2;
   logic [2:0]   fn_sel2;
   logic [63:0]  low2, high2, out2;

   int n_checks = 0;
   int n_errors = 0;
   logic [127:0] obs[$];

`ifdef IOTDF_AVG_ROUND_EN
   localparam logic [130:0] T_BIAS = 131'd4;
   localparam logic [127:0] AVG_EXP = 128'd2;
`else
   localparam logic [130:0] T_BIAS = 131'd0;
   localparam logic [127:0] AVG_EXP = 128'd1;
`endif

   iotdf_gen2 u_dut (
      .clk     (clk),
      .rst     (rst),
      .in_en   (in_en),
      .iot_in  (iot_in),
      .fn_sel  (fn_sel),
      .low     (low),
      .high    (high),
      .busy    (busy),
      .valid   (valid),
      .iot_out (iot_out)
   );

   iotdf_gen2 #(.IN_W(16), .DATA_W(64), .GROUP_N(4)) u_dut2 (
      .clk     (clk),
      .rst     (rst2),
      .in_en   (in_en2),
      .iot_in  (iot_in2),
      .fn_sel  (fn_sel2),
      .low     (low2),
      .high    (high2),
      .busy    (busy2),
      .valid   (valid2),
      .iot_out (out2)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_obs(input string nm, input int idx, input logic [127:0] v);
      if (idx < obs.size()) chk(nm, obs[idx], v);
      else begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: no result observed, expected %h", nm, v);
      end
   endtask

   // ---------------- reference model (default parameters) ----------------
   logic [127:0] m_word, m_pcur, m_out, m_peak, g_max, g_min, m_no;
   logic [130:0] g_sum;
   logic [127:0] m_grp[$];
   int           m_beats;
   bit           m_pend, m_busy, m_valid, m_pinit, m_chg, m_acc, m_nv, m_nb;
   logic [2:0]   m_fn;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_word = '0; m_pcur = '0; m_out = '0; m_peak = '0;
         m_grp.delete();
         m_beats = 0; m_pend = 0; m_busy = 0; m_valid = 0; m_pinit = 0;
         m_fn = 3'd0;
      end else begin
         m_chg = (fn_sel != m_fn);
         m_acc = in_en && !m_busy;
         m_nv = 0; m_nb = 0; m_no = m_out;
         if (m_chg) begin
            m_grp.delete();
            m_pinit = 0;
            m_peak = '0;
         end else if (m_pend) begin
            if (fn_sel == 3'd4) begin
               if (low < m_pcur && m_pcur < high) begin m_nv = 1; m_no = m_pcur; end
            end else if (fn_sel == 3'd5) begin
               if (m_pcur < low || m_pcur > high) begin m_nv = 1; m_no = m_pcur; end
            end else if (fn_sel != 3'd0) begin
               m_grp.push_back(m_pcur);
               if (m_grp.size() == 8) begin
                  g_max = m_grp[0]; g_min = m_grp[0]; g_sum = '0;
                  foreach (m_grp[i]) begin
                     if (m_grp[i] > g_max) g_max = m_grp[i];
                     if (m_grp[i] < g_min) g_min = m_grp[i];
                     g_sum = g_sum + 131'(m_grp[i]);
                  end
                  m_nb = 1;
                  case (fn_sel)
                     3'd1: begin m_nv = 1; m_no = g_max; end
                     3'd2: begin m_nv = 1; m_no = g_min; end
                     3'd3: begin m_nv = 1; m_no = 128'((g_sum + T_BIAS) >> 3); end
                     3'd6: if (!m_pinit || g_max > m_peak) begin
                        m_peak = g_max; m_pinit = 1; m_nv = 1; m_no = g_max;
                     end
                     3'd7: if (!m_pinit || g_min < m_peak) begin
                        m_peak = g_min; m_pinit = 1; m_nv = 1; m_no = g_min;
                     end
                     default: ;
                  endcase
                  m_grp.delete();
               end
            end
         end
         m_fn = fn_sel;
         m_pend = 0;
         if (m_chg) m_beats = 0;
         if (m_acc) begin
            m_word = {m_word[119:0], iot_in};
            m_beats++;
            if (m_beats == 16) begin
               m_beats = 0;
               m_pend = 1;
               m_pcur = m_word;
            end
         end
         m_valid = m_nv; m_busy = m_nb; m_out = m_no;
      end
   end

   always @(posedge clk) begin
      #1;
      chk1("busy", busy, m_busy);
      chk1("valid", valid, m_valid);
      if (m_valid) chk("iot_out", iot_out, m_out);
      if (valid) obs.push_back(iot_out);
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_beat(input logic [7:0] b);
      int g = 0;
      @(negedge clk);
      while (busy && g < 4) begin
         in_en = 1'b0;
         g++;
         @(negedge clk);
      end
      in_en = 1'b1;
      iot_in = b;
   endtask

   task automatic raw_beat(input logic [7:0] b);
      @(negedge clk);
      in_en = 1'b1;
      iot_in = b;
   endtask

   task automatic send_word(input logic [127:0] w);
      for (int i = 0; i < 16; i++) send_beat(w[127-8*i -: 8]);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_fn(input logic [2:0] f);
      idle(1);
      fn_sel = f;
      repeat (2) @(negedge clk);
      obs.delete();
   endtask

   task automatic send_beat2(input logic [15:0] b);
      int g = 0;
      @(negedge clk);
      while (busy2 && g < 4) begin
         in_en2 = 1'b0;
         g++;
         @(negedge clk);
      end
      in_en2 = 1'b1;
      iot_in2 = b;
   endtask

   task automatic send_word2(input logic [63:0] w);
      for (int i = 0; i < 4; i++) send_beat2(w[63-16*i -: 16]);
   endtask

   task automatic wait_valid2(input string nm);
      bit ok = 0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         in_en2 = 1'b0;
         if (valid2) ok = 1;
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: valid2 not seen within 40 cycles", nm);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] w6 [5];
      logic [127:0] w7 [5];
      w6 = '{128'd5, 128'd9, 128'd9, 128'd3, 128'd12};
      w7 = '{128'd5, 128'd3, 128'd3, 128'd7, 128'd1};

      rst = 1'b0; in_en = 1'b0; iot_in = '0; fn_sel = 3'd0; low = '0; high = '0;
      rst2 = 1'b0; in_en2 = 1'b0; iot_in2 = '0; fn_sel2 = 3'd2; low2 = '0; high2 = '0;
      repeat (3) @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_valid", valid, 1'b0);
      chk("rst_out", iot_out, 128'd0);
      chk("rst2_out", 128'(out2), 128'd0);
      rst = 1'b1;
      rst2 = 1'b1;

      // group max, then a word whose second beat lands while busy
      set_fn(3'd1);
      for (int i = 1; i <= 8; i++) send_word(128'(i));
      raw_beat(8'h00);
      raw_beat(8'hAA);
      for (int b = 2; b <= 16; b++) raw_beat(8'(b));
      for (int i = 1; i <= 7; i++) send_word(128'(i));
      idle(6);
      chkn("max_cnt", obs.size(), 2);
      chk_obs("max_grp1", 0, 128'h8);
      chk_obs("max_dropbeat", 1, 128'h0002030405060708090A0B0C0D0E0F10);

      // fn_sel change mid-group restarts grouping
      set_fn(3'd1);
      send_word(128'h05); send_word(128'h01); send_word(128'h02);
      idle(2);
      fn_sel = 3'd2;
      send_word(128'h30); send_word(128'h22); send_word(128'h41); send_word(128'h25);
      send_word(128'h50); send_word(128'h23); send_word(128'h29); send_word(128'h60);
      idle(6);
      chkn("chg_cnt", obs.size(), 1);
      chk_obs("chg_min", 0, 128'h22);

      set_fn(3'd3);
      send_word(128'd1);
      for (int i = 0; i < 7; i++) send_word(128'd2);
      idle(6);
      chkn("avg_cnt", obs.size(), 1);
      chk_obs("avg_val", 0, AVG_EXP);

      low = 128'h10; high = 128'h20;
      set_fn(3'd4);
      send_word(128'h10); send_word(128'h15); send_word(128'h20); send_word(128'h1F);
      idle(4);
      chkn("inr_cnt", obs.size(), 2);
      chk_obs("inr_0", 0, 128'h15);
      chk_obs("inr_1", 1, 128'h1F);

      set_fn(3'd5);
      send_word(128'h10); send_word(128'h15); send_word(128'h20); send_word(128'h1F);
      idle(4);
      chkn("exr_cnt", obs.size(), 0);

      low = 128'h20; high = 128'h10;
      set_fn(3'd5);
      send_word(128'h15); send_word(128'h30);
      idle(4);
      chkn("exr_inv_cnt", obs.size(), 2);
      chk_obs("exr_inv_1", 1, 128'h30);

      set_fn(3'd4);
      send_word(128'h15); send_word(128'h30);
      idle(4);
      chkn("inr_inv_cnt", obs.size(), 0);

      low = '0; high = '0;
      set_fn(3'd6);
      for (int g = 0; g < 5; g++) begin
         send_word(w6[g]);
         for (int i = 0; i < 7; i++) send_word(128'd1);
      end
      idle(6);
      chkn("pkmax_cnt", obs.size(), 3);
      chk_obs("pkmax_0", 0, 128'd5);
      chk_obs("pkmax_1", 1, 128'd9);
      chk_obs("pkmax_2", 2, 128'd12);

      set_fn(3'd7);
      for (int g = 0; g < 5; g++) begin
         for (int i = 0; i < 7; i++) send_word(128'hFF);
         send_word(w7[g]);
      end
      idle(6);
      chkn("pkmin_cnt", obs.size(), 3);
      chk_obs("pkmin_0", 0, 128'd5);
      chk_obs("pkmin_1", 1, 128'd3);
      chk_obs("pkmin_2", 2, 128'd1);

      // second instance: 16-bit beats, 64-bit words, groups of 4
      send_word2(64'h40); send_word2(64'h30); send_word2(64'h50); send_word2(64'h60);
      wait_valid2("p2_valid");
      chk("p2_min", 128'(out2), 128'h30);
      chk1("p2_busy", busy2, 1'b1);
      #2 rst2 = 1'b0;
      #1;
      chk1("p2_rst_valid", valid2, 1'b0);
      chk1("p2_rst_busy", busy2, 1'b0);
      chk("p2_rst_out", 128'(out2), 128'd0);
      @(negedge clk) rst2 = 1'b1;

      send_word2(64'h01); send_word2(64'h02);
      send_beat2(16'h1111); send_beat2(16'h2222);
      @(negedge clk);
      in_en2 = 1'b0;
      #2 rst2 = 1'b0;
      #1 chk1("p2_rst2_valid", valid2, 1'b0);
      @(negedge clk) rst2 = 1'b1;
      send_word2(64'h90); send_word2(64'h70); send_word2(64'h80); send_word2(64'hA0);
      wait_valid2("p2b_valid");
      chk("p2b_min", 128'(out2), 128'h70);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
